// File: rtl/read_response_buffer.sv
// read_response_buffer
//   Four-entry in-order reorder buffer between the read command pool and the
//   host response channel. Each issued read pushes a tag {tid, burst}; read
//   beats (DDR or RAW-forwarded) fill the oldest unfilled tag, masked to the
//   burst size. Responses leave strictly in tag order from entry 0.
//
//   Ports
//     clk, n_rst              clock, synchronous active-low reset
//     tid_strobe/tid_in/      tag push from the read command pool
//       burst_in
//     ddr_rvalid/ddr_rdata    DDR read beat (never back-pressured)
//     raw_valid/raw_data      RAW-forwarded beat (loses to DDR when both valid)
//     resp_valid/resp_ready/  host response channel, head entry
//       resp_data/resp_tid/
//       resp_burst
//     rbusy, rfull, count     occupancy status
//     tag_err, orphan_err     one-cycle pulses for a dropped tag / beat
module read_response_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int TID_SIZE   = 2
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  tid_strobe,
   input  logic [TID_SIZE-1:0]   tid_in,
   input  logic [1:0]            burst_in,
   input  logic                  ddr_rvalid,
   input  logic [DATA_WIDTH-1:0] ddr_rdata,
   input  logic                  raw_valid,
   input  logic [DATA_WIDTH-1:0] raw_data,
   input  logic                  resp_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [TID_SIZE-1:0]   resp_tid,
   output logic [1:0]            resp_burst,
   output logic                  rbusy,
   output logic                  rfull,
   output logic [2:0]            count,
   output logic                  tag_err,
   output logic                  orphan_err
);

   typedef struct packed {
      logic [TID_SIZE-1:0]   tid;
      logic [1:0]            burst;
      logic [DATA_WIDTH-1:0] data;
      logic                  filled;
   } entry_t;

   entry_t          ent_q [4];
   entry_t          ent_d [4];
   logic [2:0]      count_q, cnt_shift, count_d;
   logic            pop, push_ok, beat, placed;
   logic            tag_err_d, orphan_err_d;
   logic [DATA_WIDTH-1:0] beat_data;

   // Keep only the bytes covered by the burst code; the rest store as zero.
   function automatic logic [DATA_WIDTH-1:0] burst_mask(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] b);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      case (b)
         2'd0:    m[7:0]  = '1;
         2'd1:    m[15:0] = '1;
         2'd2:    m[31:0] = '1;
         default: m       = '1;
      endcase
      return d & m;
   endfunction

   always_comb begin
      ent_d        = ent_q;
      placed       = 1'b0;
      pop          = resp_valid && resp_ready;
      cnt_shift    = count_q - {2'b0, pop};

      // Pop: shift everything down; the vacated top slot returns to zero so
      // unused entries never leak stale data onto the response fields.
      if (pop) begin
         for (int i = 0; i < 3; i++) ent_d[i] = ent_q[i+1];
         ent_d[3] = '0;
      end

      // A push at count==4 fits only if this cycle's pop freed a slot.
      push_ok   = tid_strobe && (cnt_shift != 3'd4);
      tag_err_d = tid_strobe && !push_ok;
      if (push_ok) begin
         ent_d[cnt_shift[1:0]].tid    = tid_in;
         ent_d[cnt_shift[1:0]].burst  = burst_in;
         ent_d[cnt_shift[1:0]].data   = '0;
         ent_d[cnt_shift[1:0]].filled = 1'b0;
      end
      count_d = cnt_shift + {2'b0, push_ok};

      // The freshly pushed entry is part of the search, which gives the
      // same-cycle bypass for free when every older entry is already filled.
      beat      = ddr_rvalid || raw_valid;
      beat_data = ddr_rvalid ? ddr_rdata : raw_data;
      if (beat) begin
         for (int i = 0; i < 4; i++) begin
            if (!placed && (3'(i) < count_d) && !ent_d[i].filled) begin
               ent_d[i].data   = burst_mask(beat_data, ent_d[i].burst);
               ent_d[i].filled = 1'b1;
               placed          = 1'b1;
            end
         end
      end
      orphan_err_d = beat && !placed;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int i = 0; i < 4; i++) ent_q[i] <= '0;
         count_q    <= '0;
         tag_err    <= 1'b0;
         orphan_err <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) ent_q[i] <= ent_d[i];
         count_q    <= count_d;
         tag_err    <= tag_err_d;
         orphan_err <= orphan_err_d;
      end
   end

   assign resp_valid = ent_q[0].filled && (count_q != 3'd0);
   assign resp_data  = ent_q[0].data;
   assign resp_tid   = ent_q[0].tid;
   assign resp_burst = ent_q[0].burst;
   assign count      = count_q;
   assign rbusy      = (count_q != 3'd0);
   assign rfull      = (count_q == 3'd4);

endmodule
